// File: rtl/ifetch_unit.sv
// Instruction fetch unit: holds the PC, issues level-held reads to instruction
// memory, registers the returned word and flags a sticky timeout on a silent memory.
module ifetch_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PC_LdEn,
    input  logic        PC_sel,
    input  logic [15:0] PC_Immed,
    output logic        IMEM_req,
    output logic [31:0] IMEM_addr,
    input  logic        IMEM_ack,
    input  logic [31:0] IMEM_rdata,
    output logic [31:0] Instr,
    output logic        Instr_valid,
    output logic [31:0] PC,
    output logic        Fetch_err
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned WORD_W = XLEN - 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [XLEN-1:0]  NOP     = '0;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_READY = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   pc_word_q, pc_word_d;
    logic [XLEN-1:0]     instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [WORD_W-1:0]   imm_words;
    logic [WORD_W-1:0]   pc_word_next;

    // PC is kept as a word index so its two low bits are zero by construction.
    assign imm_words    = {{(WORD_W-IMM_W){PC_Immed[IMM_W-1]}}, PC_Immed};
    assign pc_word_next = PC_sel ? (pc_word_q + WORD_W'(1) + imm_words)
                                 : (pc_word_q + WORD_W'(1));

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_FETCH;
            pc_word_q <= '0;
            instr_q   <= NOP;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_word_q <= pc_word_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d   = state_q;
        pc_word_d = pc_word_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_FETCH: begin
                if (IMEM_ack) begin
                    instr_d = IMEM_rdata;
                    valid_d = 1'b1;
                    state_d = S_READY;
                end else if (cnt_q == CNT_MAX) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_READY: begin
                if (PC_LdEn) begin
                    pc_word_d = pc_word_next;
                    valid_d   = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_FETCH;
                end
            end
            S_ERROR: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Request is gated by reset so an in-flight fetch drops the instant reset asserts.
    assign IMEM_req    = Reset && (state_q == S_FETCH);
    assign PC          = {pc_word_q, 2'b00};
    assign IMEM_addr   = {pc_word_q, 2'b00};
    assign Instr       = instr_q;
    assign Instr_valid = valid_q;
    assign Fetch_err   = err_q;

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Port Clk, input, 1: single clock; all state updates on rising edge.
REQ-002 Port Reset, input, 1: asynchronous, active-low reset; asserted at 0.
REQ-003 Port PC_LdEn, input, 1: control FSM request to advance PC and fetch the next instruction.
REQ-004 Port PC_sel, input, 1: 0 = sequential (PC+4); 1 = branch target.
REQ-005 Port PC_Immed, input, 16: signed word offset for the branch target.
REQ-006 Port IMEM_req, output, 1: instruction memory read request, level-held until ack.
REQ-007 Port IMEM_addr, output, 32: byte address of the read; always equals PC.
REQ-008 Port IMEM_ack, input, 1: memory response; IMEM_rdata valid in the same cycle.
REQ-009 Port IMEM_rdata, input, 32: instruction word from memory.
REQ-010 Port Instr, output, 32: registered instruction presented to the control FSM and datapath.
REQ-011 Port Instr_valid, output, 1: Instr holds the word fetched from the current PC.
REQ-012 Port PC, output, 32: current program counter.
REQ-013 Port Fetch_err, output, 1: sticky memory timeout flag.

Function
REQ-014 States: FETCH, READY, ERROR; encoding is free; no other reachable states.
REQ-015 FETCH: IMEM_req=1 and IMEM_addr=PC.
- On an edge with IMEM_ack=1: Instr<=IMEM_rdata, Instr_valid<=1, go to READY.
REQ-016 Latency: Instr_valid rises on the edge that samples IMEM_ack; zero-wait memory (ack on the first req cycle) gives 1-cycle fetch.
REQ-017 IMEM_ack SHALL be ignored in READY and ERROR.
REQ-018 READY: IMEM_req=0; Instr and PC held stable.
- On an edge with PC_LdEn=1: update PC, Instr_valid<=0, go to FETCH.
REQ-019 Next PC, all arithmetic modulo 2^32 (wrap-around, no flag):
- PC_sel=0: PC+4.
- PC_sel=1: PC+4+(sign_extend(PC_Immed)<<2).
REQ-020 PC_LdEn in FETCH or ERROR SHALL be ignored; no PC change, no queuing.
REQ-021 Timeout counter, 4 bits, cleared on entry to FETCH:
- Increments on each FETCH edge without ack.
- An edge with count==15 and no ack sends the FSM to ERROR (16 unanswered edges).
REQ-022 ACK on the same edge as the count==15 condition SHALL be accepted normally; no error.
REQ-023 ERROR: IMEM_req=0, Fetch_err=1, Instr_valid=0; exit only by Reset.
REQ-024 PC[1:0] SHALL remain 00 in all states.

Reset
REQ-025 Reset=0 SHALL immediately, without a clock edge, force:
- PC=0x00000000, Instr=0x00000000 (NOP), Instr_valid=0, Fetch_err=0, counter=0.
- FETCH state; IMEM_req forced 0 while Reset=0.
REQ-026 After Reset rises, the first edge-free cycle SHALL present IMEM_req=1 with IMEM_addr=0x00000000; the fetch from address 0 is automatic and needs no PC_LdEn.
REQ-027 Reset asserted mid-FETCH SHALL abandon the outstanding request; a late IMEM_ack arriving while Reset=0 is ignored.

Verification
REQ-028 Release Reset; ack with rdata=0xDEADBEEF on the 3rd req cycle:
- IMEM_addr=0 throughout.
- Instr=0xDEADBEEF and Instr_valid=1 after that edge.
REQ-029 In READY with PC=0, pulse PC_LdEn=1, PC_sel=0:
- PC=0x00000004, Instr_valid=0, IMEM_req=1, IMEM_addr=0x00000004 on the next cycle.
REQ-030 In READY with PC=0x00000008, PC_LdEn=1, PC_sel=1, PC_Immed=0xFFFF:
- PC=0x00000008 (self-loop).
- With PC_Immed=0x0003: PC=0x00000018.
REQ-031 In READY with PC=0xFFFFFFFC, PC_LdEn=1, PC_sel=0:
- PC wraps to 0x00000000; fetch issued to address 0.
REQ-032 Withhold IMEM_ack for 16 edges:
- Fetch_err=1, IMEM_req=0; later ack and PC_LdEn ignored.
- Ack on the 16th edge instead gives normal capture with Fetch_err=0.
REQ-033 Drive Reset=0 mid-FETCH (PC=0x10) with ack pending:
- Outputs clear asynchronously to REQ-025 values.
- Ack during reset has no effect.
- After release, fetch restarts at 0x00000000.
